// File: rtl/rc4_mem_arbiter_pkg.sv
// Shared widths, read/write encoding and arbiter state type for the RC4 S-array arbiter.
package rc4_pkg;

  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

endpackage

// File: rtl/rc4_mem_arbiter_if.sv
// Requester handshake and S-array RAM port bundle.
// master = requester/RAM side, slave = arbiter.
interface rc4_mem_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import rc4_pkg::*;

  logic [NUM_REQ-1:0]               req_start;
  logic [NUM_REQ-1:0]               req_rw;
  logic [NUM_REQ-1:0][S_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][S_DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]               req_finish;
  logic [NUM_REQ-1:0][S_DATA_W-1:0] req_rdata;

  logic [S_ADDR_W-1:0]              mem_addr;
  logic [S_DATA_W-1:0]              mem_wdata;
  logic                             mem_wren;
  logic [S_DATA_W-1:0]              mem_q;

  modport master (
    output req_start, req_rw, req_addr, req_wdata, mem_q,
    input  req_finish, req_rdata, mem_addr, mem_wdata, mem_wren
  );

  modport slave (
    input  req_start, req_rw, req_addr, req_wdata, mem_q,
    output req_finish, req_rdata, mem_addr, mem_wdata, mem_wren
  );

endinterface

// File: rtl/rc4_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: search starts one past the last grant.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] cand;

  // First requesting index after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/rc4_mem_arbiter.sv
// Serialises init / KSA / PRGA accesses onto the single-port S-array RAM.
//
// state | meaning
// IDLE  | waiting; round-robin grant and request capture
// ISSUE | address/data on the RAM port, write strobe for writes
// WAIT  | read latency countdown, capture mem_q at zero
// DONE  | one-cycle finish pulse to the granted requester
module rc4_mem_arbiter
  import rc4_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int MEM_RD_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  rc4_mem_arbiter_if.slave           bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LAT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(MEM_RD_LAT - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  arb_state_t                       state, state_nxt;
  logic [IDX_W-1:0]                 last_grant, grant_q, pick_id;
  logic                             pick_valid;
  logic                             rw_q;
  logic [S_ADDR_W-1:0]              addr_q;
  logic [S_DATA_W-1:0]              wdata_q;
  logic [LAT_W-1:0]                 lat_cnt;
  logic [NUM_REQ-1:0][S_DATA_W-1:0] rdata_q;
  logic [NUM_REQ-1:0]               finish;
  logic                             wren;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (bus.req_start),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_id)
  );

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus the single-cycle write strobe and finish pulse.
  always_comb begin
    state_nxt = state;
    wren      = 1'b0;
    finish    = '0;
    case (state)
      IDLE:  if (pick_valid) state_nxt = ISSUE;
      ISSUE: begin
        wren      = rw_q;
        state_nxt = (rw_q == RW_WRITE) ? DONE : WAIT;
      end
      WAIT:  if (lat_cnt == '0) state_nxt = DONE;
      DONE: begin
        finish[grant_q] = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture (the only point requester inputs are sampled), latency count, read return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= LAST_INIT;
      grant_q    <= '0;
      rw_q       <= RW_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            last_grant <= pick_id;
            grant_q    <= pick_id;
            rw_q       <= bus.req_rw[pick_id];
            addr_q     <= bus.req_addr[pick_id];
            wdata_q    <= bus.req_wdata[pick_id];
          end
        end
        ISSUE: lat_cnt <= LAT_INIT;
        WAIT: begin
          if (lat_cnt == '0) rdata_q[grant_q] <= bus.mem_q;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_finish = finish;
  assign bus.req_rdata  = rdata_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wren   = wren;
  assign busy           = (state != IDLE);
  assign grant_id       = grant_q;

endmodule
